aes_core_arbiter: RTL and testbench
===================================

AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

Interface
REQ-001 SHALL have parameter DataWidth, default 128, block width in bits.
REQ-002 SHALL have parameter KeyWidth, default 256, key bus width in bits.
REQ-003 SHALL have parameter CntWidth, default 16, grant-counter width.
REQ-004 SHALL have ports:
- clk_i, in, 1, single clock.
- rst_ni, in, 1, asynchronous active-low reset.
- req_valid_i, in, 2, per-requester request valid.
- req_ready_o, out, 2, per-requester request accept.
- req_op_i, in, 2x2, ciph_op per requester.
- req_key_len_i, in, 2x3, key_len per requester.
- req_key_i, in, 2xKeyWidth, key per requester.
- req_data_i, in, 2xDataWidth, state per requester.
- core_valid_o, out, 1, request to the shared cipher core.
- core_ready_i, in, 1, core accepts the request.
- core_op_o, out, 2, latched op.
- core_key_len_o, out, 3, latched key_len.
- core_key_o, out, KeyWidth, latched key.
- core_data_o, out, DataWidth, latched state.
- core_res_valid_i, in, 1, core result valid.
- core_res_ready_o, out, 1, arbiter accepts the result.
- core_res_data_i, in, DataWidth, result state.
- core_res_err_i, in, 1, core alert.
- rsp_valid_o, out, 2, per-requester response valid.
- rsp_ready_i, in, 2, per-requester response accept.
- rsp_data_o, out, DataWidth, shared response data.
- rsp_err_o, out, 1, shared response alert.
- grant_cnt_o, out, 2xCntWidth, present only with AES_ARB_STATS_EN.

Function
REQ-005 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with exactly one operation outstanding.
REQ-006 In IDLE, the arbiter SHALL select a winner combinationally and drive req_ready_o one-hot to that winner only; req_ready_o SHALL be 0 in every other state.
REQ-007 Arbitration SHALL be round-robin: a sole requester wins; if both request, the winner is the requester not equal to last_grant.
REQ-008 On req_valid_i & req_ready_o, the arbiter SHALL latch op, key_len, key, data and the owner, update last_grant, and move to ISSUE.
REQ-009 In ISSUE, core_valid_o SHALL be 1, the cycle after acceptance; core_* outputs SHALL hold stable until core_ready_i; on core_ready_i the FSM SHALL move to WAIT.
REQ-010 In WAIT, core_res_ready_o SHALL be 1; on core_res_valid_i the arbiter SHALL register core_res_data_i and core_res_err_i and move to RESP.
REQ-011 core_res_ready_o SHALL be 0 outside WAIT; a core_res_valid_i outside WAIT SHALL be ignored.
REQ-012 In RESP, rsp_valid_o SHALL be 1 only at the owner bit, holding data and err stable until rsp_ready_i[owner], then return to IDLE.
REQ-013 Minimum latency SHALL be 3 cycles plus core latency: accept (N), core_valid_o (N+1), response valid the cycle after core_res_valid_i.
REQ-014 A request arriving in a non-IDLE state SHALL stall, never drop; new arbitration SHALL occur only in IDLE, so back-to-back requests alternate owners.
REQ-015 rsp_ready_i of the non-owner SHALL have no effect.

Reset
REQ-016 Asserting rst_ni low SHALL immediately return the FSM to IDLE, set last_grant=1, and clear all latches and counters.
REQ-017 During reset, all outputs SHALL be 0.
REQ-018 Reset mid-operation SHALL abandon the operation with no response; the next result from the core SHALL be ignored unless it arrives in WAIT.

Configuration
REQ-019 With AES_ARB_STATS_EN defined, grant_cnt_o[i] SHALL increment on each grant to requester i and saturate at all-ones.
REQ-020 Without AES_ARB_STATS_EN, the grant_cnt_o port and the counters SHALL not exist.

Structure
REQ-021 The arb_state_e typedef and the NumReq=2 constant SHALL live in a shared package, aes_arb_pkg.
REQ-022 The round-robin selector SHALL be a sub-module, aes_rr_arb2.

Verification
REQ-023 Single requester: r0 key=000102..0f, data=00112233..ff, op=encrypt; stub core returns 69c4e0d86a7b0430d8cdb78070b4c55a after 5 cycles -> rsp_valid_o=01 with that data and err=0.
REQ-024 Both requesters valid in the same cycle after reset -> r0 is granted first, then r1; grant order over 4 back-to-back pairs = 0,1,0,1,0,1,0,1.
REQ-025 core_ready_i held 0 for 10 cycles -> core_valid_o and core_data_o stay stable, req_ready_o=00 throughout.
REQ-026 rsp_ready_i[owner]=0 for 7 cycles with core_res_err_i=1 -> rsp_valid_o held, rsp_err_o=1, no new grant occurs.
REQ-027 rst_ni pulsed low during WAIT -> all outputs 0, a late core_res_valid_i causes no response, and the next request is served normally.
REQ-028 With AES_ARB_STATS_EN: 70000 grants to r0 -> grant_cnt_o[0]=FFFF and grant_cnt_o[1]=0.

Source files
------------

// File: rtl/aes_arb_pkg.sv
// Shared definitions for the two-requester AES core arbiter.
// Holds the arbiter FSM state type, the requester count and the
// ciph_op / key_len encodings carried through to the cipher core.
package aes_arb_pkg;

    localparam int NumReq = 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    // Cipher operation and key length encodings seen on the request bus.
    localparam logic [1:0] CIPH_OP_ENC = 2'b01;
    localparam logic [1:0] CIPH_OP_DEC = 2'b10;

    localparam logic [2:0] KEY_LEN_128 = 3'b001;
    localparam logic [2:0] KEY_LEN_192 = 3'b010;
    localparam logic [2:0] KEY_LEN_256 = 3'b100;

    // One-hot vector for a requester index.
    function automatic logic [NumReq-1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin selector.
// A sole requester always wins; with both requesting, the one that was
// not granted last time wins. Purely combinational.
module aes_rr_arb2
    import aes_arb_pkg::*;
(
    input  logic [NumReq-1:0] req_i,
    input  logic              last_grant_i,
    output logic [NumReq-1:0] gnt_o,
    output logic              gnt_idx_o
);

    // Pick the winner from the current request pattern and last grant.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        gnt_o     = '0;
        gnt_idx_o = 1'b0;
        case (req_i)
            2'b01: begin
                gnt_idx_o = 1'b0;
                gnt_o     = 2'b01;
            end
            2'b10: begin
                gnt_idx_o = 1'b1;
                gnt_o     = 2'b10;
            end
            2'b11: begin
                gnt_idx_o = ~last_grant_i;
                gnt_o     = req_onehot(~last_grant_i);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/aes_core_arbiter.sv
// Arbiter sharing one AES cipher core between two requesters.
// One operation is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP.
// The winning request is latched, handed to the core, the result is
// registered and returned to the owning requester only.
// Optional feature: define AES_ARB_STATS_EN to add per-requester
// saturating grant counters on grant_cnt_o.
module aes_core_arbiter
    import aes_arb_pkg::*;
#(
    parameter int DataWidth = 128,
    parameter int KeyWidth  = 256,
    parameter int CntWidth  = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,

    input  logic [NumReq-1:0]                    req_valid_i,
    output logic [NumReq-1:0]                    req_ready_o,
    input  logic [NumReq-1:0][1:0]               req_op_i,
    input  logic [NumReq-1:0][2:0]               req_key_len_i,
    input  logic [NumReq-1:0][KeyWidth-1:0]      req_key_i,
    input  logic [NumReq-1:0][DataWidth-1:0]     req_data_i,

    output logic                                 core_valid_o,
    input  logic                                 core_ready_i,
    output logic [1:0]                           core_op_o,
    output logic [2:0]                           core_key_len_o,
    output logic [KeyWidth-1:0]                  core_key_o,
    output logic [DataWidth-1:0]                 core_data_o,

    input  logic                                 core_res_valid_i,
    output logic                                 core_res_ready_o,
    input  logic [DataWidth-1:0]                 core_res_data_i,
    input  logic                                 core_res_err_i,

    output logic [NumReq-1:0]                    rsp_valid_o,
    input  logic [NumReq-1:0]                    rsp_ready_i,
    output logic [DataWidth-1:0]                 rsp_data_o,
    output logic                                 rsp_err_o
`ifdef AES_ARB_STATS_EN
    ,
    output logic [NumReq-1:0][CntWidth-1:0]      grant_cnt_o
`endif
);

    arb_state_e          state_q, state_d;
    logic                last_grant_q;
    logic                owner_q;
    logic [NumReq-1:0]   arb_gnt;
    logic                arb_idx;
    logic                accept;
    logic                res_capture;

    aes_rr_arb2 u_rr_arb (
        .req_i        (req_valid_i),
        .last_grant_i (last_grant_q),
        .gnt_o        (arb_gnt),
        .gnt_idx_o    (arb_idx)
    );

    // Handshake qualifiers shared by the FSM and the datapath registers.
    assign accept      = |(req_valid_i & req_ready_o);
    assign res_capture = (state_q == ARB_WAIT) && core_res_valid_i;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs decoded from the current state.
    always_comb begin
        state_d          = state_q;
        req_ready_o      = '0;
        core_valid_o     = 1'b0;
        core_res_ready_o = 1'b0;
        rsp_valid_o      = '0;
        case (state_q)
            ARB_IDLE: begin
                // Gated by rst_ni so ready reads 0 while reset is held,
                // even though the selector itself is combinational.
                req_ready_o = rst_ni ? arb_gnt : '0;
                if (accept) begin
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                core_valid_o = 1'b1;
                if (core_ready_i) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                core_res_ready_o = 1'b1;
                if (core_res_valid_i) begin
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                rsp_valid_o = req_onehot(owner_q);
                if (rsp_ready_i[owner_q]) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Round-robin history and ownership of the operation in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
        end else if (accept) begin
            last_grant_q <= arb_idx;
            owner_q      <= arb_idx;
        end
    end

    // Latch the winning request; held stable until the next acceptance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: wide datapath registers are reset here because they drive outputs that must read 0 during reset.
        if (!rst_ni) begin
            core_op_o      <= '0;
            core_key_len_o <= '0;
            core_key_o     <= '0;
            core_data_o    <= '0;
        end else if (accept) begin
            core_op_o      <= req_op_i[arb_idx];
            core_key_len_o <= req_key_len_i[arb_idx];
            core_key_o     <= req_key_i[arb_idx];
            core_data_o    <= req_data_i[arb_idx];
        end
    end

    // Register the core result; results arriving outside WAIT are dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_data_o <= '0;
            rsp_err_o  <= 1'b0;
        end else if (res_capture) begin
            rsp_data_o <= core_res_data_i;
            rsp_err_o  <= core_res_err_i;
        end
    end

`ifdef AES_ARB_STATS_EN
    // Per-requester grant counters, saturating at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_cnt_o <= '0;
        end else begin
            for (int i = 0; i < NumReq; i++) begin
                if (accept && arb_gnt[i] && !(&grant_cnt_o[i])) begin
                    grant_cnt_o[i] <= grant_cnt_o[i] + CntWidth'(1);
                end
            end
        end
    end
`else
    // CntWidth only sizes the optional counters.
    logic unused_cnt_width;
    assign unused_cnt_width = |CntWidth;
`endif

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed self-checking bench for aes_core_arbiter.
// Drives inputs just after the falling edge and samples 1 time unit later,
// well away from the rising edge. Define AES_ARB_STATS_EN to also
// exercise the grant counters.
module tb_aes_core_arbiter;
    import aes_arb_pkg::*;

    localparam int DW = 128;
    localparam int KW = 256;
    localparam int CW = 16;

    localparam logic [KW-1:0] KEY_A  = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [DW-1:0] DATA_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [DW-1:0] RES_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                    clk_i = 1'b0;
    logic                    rst_ni = 1'b0;
    logic [1:0]              req_valid_i;
    logic [1:0]              req_ready_o;
    logic [1:0][1:0]         req_op_i;
    logic [1:0][2:0]         req_key_len_i;
    logic [1:0][KW-1:0]      req_key_i;
    logic [1:0][DW-1:0]      req_data_i;
    logic                    core_valid_o;
    logic                    core_ready_i;
    logic [1:0]              core_op_o;
    logic [2:0]              core_key_len_o;
    logic [KW-1:0]           core_key_o;
    logic [DW-1:0]           core_data_o;
    logic                    core_res_valid_i;
    logic                    core_res_ready_o;
    logic [DW-1:0]           core_res_data_i;
    logic                    core_res_err_i;
    logic [1:0]              rsp_valid_o;
    logic [1:0]              rsp_ready_i;
    logic [DW-1:0]           rsp_data_o;
    logic                    rsp_err_o;
`ifdef AES_ARB_STATS_EN
    logic [1:0][CW-1:0]      grant_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    aes_core_arbiter #(
        .DataWidth (DW),
        .KeyWidth  (KW),
        .CntWidth  (CW)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_op_i         (req_op_i),
        .req_key_len_i    (req_key_len_i),
        .req_key_i        (req_key_i),
        .req_data_i       (req_data_i),
        .core_valid_o     (core_valid_o),
        .core_ready_i     (core_ready_i),
        .core_op_o        (core_op_o),
        .core_key_len_o   (core_key_len_o),
        .core_key_o       (core_key_o),
        .core_data_o      (core_data_o),
        .core_res_valid_i (core_res_valid_i),
        .core_res_ready_o (core_res_ready_o),
        .core_res_data_i  (core_res_data_i),
        .core_res_err_i   (core_res_err_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rsp_ready_i),
        .rsp_data_o       (rsp_data_o),
        .rsp_err_o        (rsp_err_o)
`ifdef AES_ARB_STATS_EN
        ,
        .grant_cnt_o      (grant_cnt_o)
`endif
    );

    // Advance to just after the next falling edge.
    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    // True when every DUT output is zero.
    function automatic bit outputs_zero();
        bit z;
        z = (req_ready_o == 2'b00) && !core_valid_o && (core_op_o == 2'b00) &&
            (core_key_len_o == 3'b000) && (core_key_o == '0) && (core_data_o == '0) &&
            !core_res_ready_o && (rsp_valid_o == 2'b00) && (rsp_data_o == '0) && !rsp_err_o;
`ifdef AES_ARB_STATS_EN
        z = z && (grant_cnt_o == '0);
`endif
        return z;
    endfunction

    // Run one operation with core_ready_i/rsp_ready_i already high:
    // waits for a grant, answers the core one cycle into WAIT, returns
    // in RESP with the observed owner and response.
    task automatic serve_one(output int owner, output logic [1:0] rsp_v,
                             output logic [DW-1:0] rsp_d, output bit ok);
        int n;
        ok = 1'b0;
        owner = -1;
        rsp_v = '0;
        rsp_d = '0;
        #1;
        n = 0;
        while (req_ready_o == 2'b00 && n < 20) begin
            step();
            n++;
        end
        if (req_ready_o == 2'b00) return;
        owner = req_ready_o[1] ? 1 : 0;
        step();
        n = 0;
        while (!core_res_ready_o && n < 20) begin
            step();
            n++;
        end
        if (!core_res_ready_o) return;
        core_res_valid_i = 1'b1;
        step();
        core_res_valid_i = 1'b0;
        rsp_v = rsp_valid_o;
        rsp_d = rsp_data_o;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni           = 1'b0;
        req_valid_i      = 2'b11;
        req_op_i         = {CIPH_OP_DEC, CIPH_OP_ENC};
        req_key_len_i    = {KEY_LEN_256, KEY_LEN_128};
        req_key_i        = {KEY_A, KEY_A};
        req_data_i       = {DATA_A, DATA_A};
        core_ready_i     = 1'b1;
        core_res_valid_i = 1'b1;
        core_res_data_i  = RES_A;
        core_res_err_i   = 1'b1;
        rsp_ready_i      = 2'b11;
        step();
        step();
        checks++;
        if (outputs_zero() !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs got ready=%b cv=%b crr=%b rv=%b err=%b op=%h data=%h required all zero",
                     req_ready_o, core_valid_o, core_res_ready_o, rsp_valid_o, rsp_err_o, core_op_o, core_data_o);
        end
        req_valid_i      = 2'b00;
        core_ready_i     = 1'b0;
        core_res_valid_i = 1'b0;
        core_res_err_i   = 1'b0;
        rsp_ready_i      = 2'b00;
        step();
        rst_ni = 1'b1;
        step();
        checks++;
        if (rsp_valid_o !== 2'b00 || core_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rv=%b cv=%b required rv=00 cv=0", rsp_valid_o, core_valid_o);
        end
    endtask

    task automatic test_round_robin();
        int          owner;
        logic [1:0]  rv;
        logic [DW-1:0] rd;
        bit          ok;
        core_ready_i    = 1'b1;
        rsp_ready_i     = 2'b11;
        core_res_data_i = 128'ha5a5_0000_1111_2222_3333_4444_5555_5a5a;
        req_valid_i     = 2'b11;
        for (int i = 0; i < 8; i++) begin
            serve_one(owner, rv, rd, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rr_timeout got no grant/result in op %0d required completion", i);
            end
            checks++;
            if (owner !== (i % 2)) begin
                errors++;
                $display("FAIL rr_order op %0d got owner %0d required %0d", i, owner, i % 2);
            end
            checks++;
            if (rv !== ((i % 2) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL rr_rsp_valid op %0d got %b required %b", i, rv, (i % 2) ? 2'b10 : 2'b01);
            end
        end
        req_valid_i = 2'b00;
        step();
        core_ready_i = 1'b0;
        rsp_ready_i  = 2'b00;
        checks++;
        if (rsp_valid_o !== 2'b00) begin
            errors++;
            $display("FAIL rr_drain got rv=%b required 00", rsp_valid_o);
        end
    endtask

    task automatic test_single();
        req_op_i[0]      = CIPH_OP_ENC;
        req_key_len_i[0] = KEY_LEN_128;
        req_key_i[0]     = KEY_A;
        req_data_i[0]    = DATA_A;
        req_valid_i      = 2'b01;
        #1;
        checks++;
        if (req_ready_o !== 2'b01 || core_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_accept got ready=%b cv=%b required ready=01 cv=0", req_ready_o, core_valid_o);
        end
        step();
        req_valid_i = 2'b00;
        checks++;
        if (core_valid_o !== 1'b1 || req_ready_o !== 2'b00) begin
            errors++;
            $display("FAIL single_issue got cv=%b ready=%b required cv=1 ready=00", core_valid_o, req_ready_o);
        end
        checks++;
        if (core_key_o !== KEY_A || core_data_o !== DATA_A ||
            core_op_o !== CIPH_OP_ENC || core_key_len_o !== KEY_LEN_128) begin
            errors++;
            $display("FAIL single_payload got op=%h kl=%h key=%h data=%h required op=%h kl=%h key=%h data=%h",
                     core_op_o, core_key_len_o, core_key_o, core_data_o, CIPH_OP_ENC, KEY_LEN_128, KEY_A, DATA_A);
        end
        core_ready_i = 1'b1;
        step();
        core_ready_i = 1'b0;
        checks++;
        if (core_res_ready_o !== 1'b1 || core_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_wait got crr=%b cv=%b required crr=1 cv=0", core_res_ready_o, core_valid_o);
        end
        repeat (4) step();
        core_res_valid_i = 1'b1;
        core_res_data_i  = RES_A;
        core_res_err_i   = 1'b0;
        step();
        core_res_valid_i = 1'b0;
        core_res_data_i  = '0;
        checks++;
        if (rsp_valid_o !== 2'b01 || rsp_data_o !== RES_A || rsp_err_o !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp got rv=%b data=%h err=%b required rv=01 data=%h err=0",
                     rsp_valid_o, rsp_data_o, rsp_err_o, RES_A);
        end
        checks++;
        if (core_res_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL single_crr_resp got %b required 0", core_res_ready_o);
        end
        rsp_ready_i = 2'b01;
        step();
        rsp_ready_i = 2'b00;
        checks++;
        if (rsp_valid_o !== 2'b00) begin
            errors++;
            $display("FAIL single_done got rv=%b required 00", rsp_valid_o);
        end
    endtask

    task automatic test_core_stall();
        logic [DW-1:0] d2;
        logic [DW-1:0] r2;
        d2 = 128'hdead_beef_0123_4567_89ab_cdef_f00d_cafe;
        r2 = 128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0;
        req_op_i[1]      = CIPH_OP_DEC;
        req_key_len_i[1] = KEY_LEN_256;
        req_key_i[1]     = ~KEY_A;
        req_data_i[1]    = d2;
        req_valid_i      = 2'b10;
        #1;
        checks++;
        if (req_ready_o !== 2'b10) begin
            errors++;
            $display("FAIL stall_accept got ready=%b required 10", req_ready_o);
        end
        step();
        req_valid_i = 2'b11;
        req_data_i[1] = '0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (core_valid_o !== 1'b1 || core_data_o !== d2 || core_key_o !== ~KEY_A) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got cv=%b data=%h required cv=1 data=%h", i, core_valid_o, core_data_o, d2);
            end
            checks++;
            if (req_ready_o !== 2'b00) begin
                errors++;
                $display("FAIL stall_ready cycle %0d got %b required 00", i, req_ready_o);
            end
            step();
        end
        core_ready_i = 1'b1;
        step();
        core_ready_i = 1'b0;
        req_valid_i  = 2'b00;
        checks++;
        if (core_res_ready_o !== 1'b1 || core_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_wait got crr=%b cv=%b required crr=1 cv=0", core_res_ready_o, core_valid_o);
        end
        core_res_valid_i = 1'b1;
        core_res_data_i  = r2;
        step();
        core_res_valid_i = 1'b0;
        checks++;
        if (rsp_valid_o !== 2'b10 || rsp_data_o !== r2) begin
            errors++;
            $display("FAIL stall_rsp got rv=%b data=%h required rv=10 data=%h", rsp_valid_o, rsp_data_o, r2);
        end
        rsp_ready_i = 2'b10;
        step();
        rsp_ready_i = 2'b00;
        checks++;
        if (rsp_valid_o !== 2'b00) begin
            errors++;
            $display("FAIL stall_done got rv=%b required 00", rsp_valid_o);
        end
    endtask

    task automatic test_resp_hold();
        logic [DW-1:0] r3;
        r3 = 128'h1357_9bdf_0246_8ace_fdb9_7531_eca8_6420;
        req_data_i[0] = DATA_A;
        req_valid_i   = 2'b01;
        step();
        req_valid_i  = 2'b00;
        core_ready_i = 1'b1;
        step();
        core_ready_i = 1'b0;
        checks++;
        if (core_res_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL hold_wait got crr=%b required 1", core_res_ready_o);
        end
        core_res_valid_i = 1'b1;
        core_res_data_i  = r3;
        core_res_err_i   = 1'b1;
        step();
        core_res_valid_i = 1'b0;
        core_res_err_i   = 1'b0;
        core_res_data_i  = '0;
        req_valid_i      = 2'b11;
        rsp_ready_i      = 2'b10;
        for (int i = 0; i < 7; i++) begin
            #1;
            checks++;
            if (rsp_valid_o !== 2'b01 || rsp_err_o !== 1'b1 || rsp_data_o !== r3) begin
                errors++;
                $display("FAIL hold_rsp cycle %0d got rv=%b err=%b data=%h required rv=01 err=1 data=%h",
                         i, rsp_valid_o, rsp_err_o, rsp_data_o, r3);
            end
            checks++;
            if (req_ready_o !== 2'b00 || core_res_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL hold_no_grant cycle %0d got ready=%b crr=%b required ready=00 crr=0",
                         i, req_ready_o, core_res_ready_o);
            end
            // A stray core result while in RESP must be ignored.
            if (i == 2) begin
                core_res_valid_i = 1'b1;
                core_res_data_i  = 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff;
            end else if (i == 3) begin
                core_res_valid_i = 1'b0;
                core_res_data_i  = '0;
            end
            step();
        end
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b01;
        step();
        rsp_ready_i = 2'b00;
        checks++;
        if (rsp_valid_o !== 2'b00 || core_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL hold_done got rv=%b cv=%b required rv=00 cv=0", rsp_valid_o, core_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        int            owner;
        logic [1:0]    rv;
        logic [DW-1:0] rd;
        logic [DW-1:0] r4;
        bit            ok;
        r4 = 128'h2468_ace0_1357_9bdf_8642_0eca_fdb9_7531;
        req_valid_i = 2'b10;
        step();
        req_valid_i  = 2'b00;
        core_ready_i = 1'b1;
        step();
        core_ready_i = 1'b0;
        checks++;
        if (core_res_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_wait got crr=%b required 1", core_res_ready_o);
        end
        rst_ni      = 1'b0;
        req_valid_i = 2'b11;
        #1;
        checks++;
        if (outputs_zero() !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_async got ready=%b cv=%b crr=%b rv=%b data=%h required all zero",
                     req_ready_o, core_valid_o, core_res_ready_o, rsp_valid_o, core_data_o);
        end
        step();
        checks++;
        if (outputs_zero() !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_held got ready=%b cv=%b crr=%b rv=%b required all zero",
                     req_ready_o, core_valid_o, core_res_ready_o, rsp_valid_o);
        end
        req_valid_i = 2'b00;
        rst_ni      = 1'b1;
        core_res_valid_i = 1'b1;
        core_res_data_i  = 128'hbad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rsp_valid_o !== 2'b00 || core_res_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_late cycle %0d got rv=%b crr=%b required rv=00 crr=0",
                         i, rsp_valid_o, core_res_ready_o);
            end
        end
        core_res_valid_i = 1'b0;
        core_res_data_i  = r4;
        core_ready_i     = 1'b1;
        rsp_ready_i      = 2'b11;
        req_valid_i      = 2'b11;
        serve_one(owner, rv, rd, ok);
        req_valid_i = 2'b00;
        checks++;
        if (!ok || owner !== 0) begin
            errors++;
            $display("FAIL rstmid_next_owner got ok=%0d owner=%0d required ok=1 owner=0", ok, owner);
        end
        checks++;
        if (rv !== 2'b01 || rd !== r4) begin
            errors++;
            $display("FAIL rstmid_next_rsp got rv=%b data=%h required rv=01 data=%h", rv, rd, r4);
        end
        step();
        core_ready_i = 1'b0;
        rsp_ready_i  = 2'b00;
    endtask

`ifdef AES_ARB_STATS_EN
    task automatic test_stats();
        int grants;
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        step();
        grants           = 0;
        core_ready_i     = 1'b1;
        core_res_valid_i = 1'b1;
        rsp_ready_i      = 2'b11;
        req_valid_i      = 2'b01;
        for (int n = 0; n < 300000 && grants < 70000; n++) begin
            #1;
            if (req_ready_o[0]) grants++;
            if (grants == 70000) req_valid_i = 2'b00;
            step();
        end
        req_valid_i = 2'b00;
        repeat (5) step();
        core_res_valid_i = 1'b0;
        core_ready_i     = 1'b0;
        rsp_ready_i      = 2'b00;
        checks++;
        if (grants !== 70000) begin
            errors++;
            $display("FAIL stats_timeout got %0d grants required 70000", grants);
        end
        checks++;
        if (grant_cnt_o[0] !== 16'hffff || grant_cnt_o[1] !== 16'h0000) begin
            errors++;
            $display("FAIL stats_cnt got cnt0=%h cnt1=%h required cnt0=ffff cnt1=0000",
                     grant_cnt_o[0], grant_cnt_o[1]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_core_stall();
        test_resp_hold();
        test_reset_mid();
`ifdef AES_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
